// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side consumer for async_fifo, living entirely in the FIFO read clock
// domain. It issues read requests to the FIFO, captures the registered read
// data one cycle after each accepted read, and presents the words downstream
// as a valid/ready stream through a 2-entry skid buffer. Sustains one word per
// cycle and never drops or duplicates a word under backpressure.
//
// Optional feature (compile-time macro FIFO_RD_STREAM_STATS_EN):
//   defined   -> o_word_cnt counts delivered words (pops), wrapping modulo
//                2^CNT_WIDTH; cleared by reset only, not by i_flush.
//   undefined -> o_word_cnt is tied to zero and no counter flops exist.
//
// Parameters:
//   LOGIC_SIZE  data word width, must match the FIFO's LOGIC_SIZE
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports:
//   i_clk          FIFO read clock (shared with async_fifo i_rclk)
//   i_rst_n        asynchronous active-low reset
//   o_fifo_rr      read request to the FIFO
//   i_fifo_rdata   FIFO registered read data
//   i_fifo_rempty  FIFO empty flag
//   i_flush        synchronous discard of buffered and in-flight words
//   o_valid        stream data valid
//   i_ready        downstream ready
//   o_data         stream data (head of the skid buffer)
//   o_word_cnt     delivered-word count (zero unless the macro is defined)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int LOGIC_SIZE = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_fifo_rr,
  input  logic [LOGIC_SIZE-1:0] i_fifo_rdata,
  input  logic                  i_fifo_rempty,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LOGIC_SIZE-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_word_cnt
);

  logic [1:0]            count_reg, count_next;
  logic                  inflight_reg;
  logic [LOGIC_SIZE-1:0] entry0_reg, entry0_next;  // head
  logic [LOGIC_SIZE-1:0] entry1_reg, entry1_next;
  logic                  push;
  logic                  pop;
  logic [2:0]            level_after_pop;

  assign pop     = o_valid & i_ready;
  assign push    = inflight_reg;
  assign o_valid = (count_reg != 2'd0);
  assign o_data  = entry0_reg;

  // Occupancy the buffer will have once this cycle's pop leaves, counting the
  // word already on its way back from the FIFO. A new read is only issued if
  // that word still fits; using the pop here (i_ready -> o_fifo_rr path) is
  // what keeps full throughput with only two entries.
  assign level_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign o_fifo_rr       = ~i_flush & ~i_fifo_rempty & (level_after_pop < 3'd2);

  always_comb begin
    count_next  = count_reg;
    entry0_next = entry0_reg;
    entry1_next = entry1_reg;
    if (i_flush) begin
      // The word returning this cycle (if any) is dropped along with the
      // buffered ones; entry contents are left stale since count gates them.
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) entry0_next = i_fifo_rdata;
          else                   entry1_next = i_fifo_rdata;
          count_next = count_reg + 2'd1;
        end
        2'b01: begin
          entry0_next = entry1_reg;
          count_next  = count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            entry0_next = i_fifo_rdata;
          end else begin
            entry0_next = entry1_reg;
            entry1_next = i_fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      entry0_reg   <= '0;
      entry1_reg   <= '0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= o_fifo_rr & ~i_fifo_rempty;
      entry0_reg   <= entry0_next;
      entry1_reg   <= entry1_next;
    end
  end

  // A returning word must always find a free entry.
  a_no_push_when_full : assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(push && count_reg == 2'd2)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] word_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  word_cnt_reg <= '0;
    else if (pop)  word_cnt_reg <= word_cnt_reg + CNT_ONE;
  end

  assign o_word_cnt = word_cnt_reg;
`else
  assign o_word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
//
// Self-checking bench for fifo_rd_stream. The FIFO is modelled as a queue with
// a registered read port. A scoreboard records every word the FIFO hands out,
// removes words as they are delivered downstream, and forgets them on flush or
// reset; each delivered word must match the oldest outstanding one. Directed
// scenarios cover latency, backpressure, flush and asynchronous reset, then a
// randomized phase mixes writes, ready and flush.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int LS = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_rr;
  logic [LS-1:0] fifo_rdata;
  logic          fifo_empty;
  logic          flush;
  logic          valid;
  logic          ready;
  logic [LS-1:0] data;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(.LOGIC_SIZE(LS), .CNT_WIDTH(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_fifo_rr     (fifo_rr),
    .i_fifo_rdata  (fifo_rdata),
    .i_fifo_rempty (fifo_empty),
    .i_flush       (flush),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_data        (data),
    .o_word_cnt    (word_cnt)
  );

  int            checks = 0;
  int            errors = 0;
  logic [LS-1:0] fifo_q[$];     // words still inside the FIFO
  logic [LS-1:0] exp_q[$];      // words read out of the FIFO, not yet delivered
  int            acc_cnt = 0;
  int            dlv_cnt = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          hold_prev = 1'b0;
  logic [LS-1:0] hold_data = '0;
  logic          acc_pending = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] actual,
                          input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic fifo_write(input logic [LS-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // Called at the falling edge: decides what the next rising edge does and
  // checks the stream against the outstanding-word scoreboard.
  task automatic monitor();
    logic acc;
    logic pop;
    if (!rst_n) begin
      exp_q.delete();
      hold_prev   = 1'b0;
      exp_cnt     = '0;
      acc_pending = 1'b0;
      return;
    end
    acc = fifo_rr && !fifo_empty;
    pop = valid && ready;
    if (fifo_rr) check_eq("rr_underflow", 32'(fifo_empty), 32'd0);
    if (exp_q.size() == 0) check_eq("valid_idle", 32'(valid), 32'd0);
    if (hold_prev) begin
      check_eq("hold_valid", 32'(valid), 32'd1);
      check_eq("hold_data", 32'(data), 32'(hold_data));
    end
    check_eq("word_cnt", 32'(word_cnt), 32'(exp_cnt));
    if (pop) begin
      check_eq("pop_has_word", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check_eq("pop_data", 32'(data), 32'(exp_q[0]));
        $display("xfer %0d data=%02h", dlv_cnt, data);
        void'(exp_q.pop_front());
      end
      dlv_cnt++;
`ifdef FIFO_RD_STREAM_STATS_EN
      exp_cnt++;
`endif
    end
    if (flush) exp_q.delete();
    if (acc) begin
      exp_q.push_back(fifo_q[0]);
      acc_cnt++;
    end
    check_eq("occupancy_le2", 32'(exp_q.size() <= 2), 32'd1);
    hold_prev   = valid && !ready && !flush;
    hold_data   = data;
    acc_pending = acc;
  endtask

  // One clock cycle; returns 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rst_n && acc_pending) begin
      fifo_rdata = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !valid) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acc0;
    int   dlv0;

    // ---------------- reset ----------------
    rst_n      = 1'b0;
    ready      = 1'b0;
    flush      = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    #1;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_data", 32'(data), 32'd0);
    check_eq("rst_rr", 32'(fifo_rr), 32'd0);
    check_eq("rst_word_cnt", 32'(word_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---------------- three words, ready high ----------------
    acc0 = acc_cnt;
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    ready = 1'b1;
    #1;
    check_eq("lat_rr_same_cycle", 32'(fifo_rr), 32'd1);
    tick();
    check_eq("lat_valid_1cyc", 32'(valid), 32'd0);
    tick();
    check_eq("seq3_v0", 32'(valid), 32'd1);
    check_eq("seq3_d0", 32'(data), 32'h11);
    tick();
    check_eq("seq3_v1", 32'(valid), 32'd1);
    check_eq("seq3_d1", 32'(data), 32'h22);
    tick();
    check_eq("seq3_v2", 32'(valid), 32'd1);
    check_eq("seq3_d2", 32'(data), 32'h33);
    tick();
    check_eq("seq3_valid_after", 32'(valid), 32'd0);
    check_eq("seq3_accepts", 32'(acc_cnt - acc0), 32'd3);

    // ---------------- backpressure then full-rate release ----------------
    ready = 1'b0;
    for (int k = 0; k < 8; k++) fifo_write(8'hA0 + 8'(k));
    for (int k = 0; k < 5; k++) tick();
    check_eq("bp_rr_low", 32'(fifo_rr), 32'd0);
    check_eq("bp_valid", 32'(valid), 32'd1);
    check_eq("bp_head", 32'(data), 32'hA0);
    check_eq("bp_fifo_left", 32'(fifo_q.size()), 32'd6);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_eq("tput_valid", 32'(valid), 32'd1);
      check_eq("tput_data", 32'(data), 32'hA0 + 32'(k));
      tick();
    end
    check_eq("tput_valid_after", 32'(valid), 32'd0);

    // ---------------- ready toggling, 32 random words ----------------
    dlv0 = dlv_cnt;
    for (int k = 0; k < 32; k++) fifo_write(8'($urandom));
    for (int k = 0; k < 120; k++) begin
      ready = ~ready;
      tick();
    end
    check_eq("toggle_delivered", 32'(dlv_cnt - dlv0), 32'd32);
    ready = 1'b1;
    wait_idle("toggle_drain", 20);

    // ---------------- flush with words buffered and in flight ----------------
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) fifo_write(8'(k));
    for (int k = 0; k < 4; k++) tick();
    check_eq("fl_head", 32'(data), 32'h01);
    ready = 1'b1;            // deliver 0x01, 0x03 gets read
    tick();
    ready = 1'b0;
    flush = 1'b1;            // discards 0x02 (buffered) and 0x03 (in flight)
    #1;
    check_eq("fl_rr_low", 32'(fifo_rr), 32'd0);
    tick();
    flush = 1'b0;
    check_eq("fl_valid_low", 32'(valid), 32'd0);
    ready = 1'b1;
    wait_valid("fl_resume_seen", 10);
    check_eq("fl_resume_data", 32'(data), 32'h04);
    tick();
    check_eq("fl_next_data", 32'(data), 32'h05);
    wait_idle("fl_drain", 20);

    // ---------------- asynchronous reset mid-stream ----------------
    ready = 1'b0;
    for (int k = 0; k < 6; k++) fifo_write(8'h31 + 8'(k));
    for (int k = 0; k < 4; k++) tick();
    check_eq("ar_pre_valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;            // the FIFO shares this reset
    fifo_q.delete();
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    #1;
    check_eq("ar_valid", 32'(valid), 32'd0);
    check_eq("ar_rr", 32'(fifo_rr), 32'd0);
    check_eq("ar_data", 32'(data), 32'd0);
    check_eq("ar_word_cnt", 32'(word_cnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check_eq("ar_post_valid", 32'(valid), 32'd0);
    fifo_write(8'h7E);
    fifo_write(8'h7F);
    ready = 1'b1;
    wait_valid("ar_resume_seen", 10);
    check_eq("ar_resume_data", 32'(data), 32'h7E);
    wait_idle("ar_drain", 20);

    // ---------------- randomized traffic ----------------
    for (int k = 0; k < 400; k++) begin
      ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (fifo_q.size() < 12 && $urandom_range(0, 1) == 1) fifo_write(8'($urandom));
      tick();
    end
    flush = 1'b0;
    ready = 1'b1;
    wait_idle("rand_drain", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
